// File: rtl/multiword_add_pkg.sv
// Shared slice width and FSM state encoding for the sequential multiword adder.
package multiword_add_pkg;
  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/adder16_core.sv
// Combinational SLICE_W-bit adder with carry-in and carry-out; zero latency, no flow control.
module adder16_core
  import multiword_add_pkg::*;
(
  input  logic [SLICE_W-1:0] i_x,
  input  logic [SLICE_W-1:0] i_y,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_s,
  output logic               o_cout
);

  assign {o_cout, o_s} = {1'b0, i_x} + {1'b0, i_y} + {{SLICE_W{1'b0}}, i_cin};

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential N-bit adder, one 16-bit slice per cycle; out_valid rises WORDS cycles after accept.
// Result held until out_ready; in_ready only in IDLE. Define MULTIWORD_ADD_SIGNED_OVF_EN for the ovf output.
module multiword_add_seq
  import multiword_add_pkg::*;
#(
  parameter int WORDS = 4
)
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SLICE_W*WORDS-1:0]   a,
  input  logic [SLICE_W*WORDS-1:0]   b,
  input  logic                       cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SLICE_W*WORDS-1:0]   sum,
  output logic                       cout
`ifdef MULTIWORD_ADD_SIGNED_OVF_EN
  ,
  output logic                       ovf
`endif
);

  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [IDX_W-1:0]                r_idx;
  logic                            r_carry;
  logic [WORDS-1:0][SLICE_W-1:0]   r_a;
  logic [WORDS-1:0][SLICE_W-1:0]   r_b;
  logic [WORDS-1:0][SLICE_W-1:0]   r_sum;
  logic                            r_cout;
  logic [SLICE_W-1:0]              w_x;
  logic [SLICE_W-1:0]              w_y;
  logic [SLICE_W-1:0]              w_s;
  logic                            w_co;
  logic                            w_last;
  logic                            w_accept;

  assign w_x      = r_a[r_idx];
  assign w_y      = r_b[r_idx];
  assign w_last   = (r_idx == LAST_IDX);
  assign w_accept = in_valid && (r_state == IDLE);
  assign sum      = r_sum;
  assign cout     = r_cout;

  adder16_core u_core (
    .i_x    (w_x),
    .i_y    (w_y),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ADD;
      end
      ADD: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operands are captured once; later a/b/cin changes cannot disturb an add in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
    end else if (r_state == ADD) begin
      r_sum[r_idx] <= w_s;
      r_carry      <= w_co;
      r_idx        <= r_idx + 1'b1;
      if (w_last) r_cout <= w_co;
    end
  end

`ifdef MULTIWORD_ADD_SIGNED_OVF_EN
  logic r_ovf;
  logic w_msb_cin;

  // Carry into the top bit is recovered from the top-bit sum: s = x ^ y ^ c.
  assign w_msb_cin = w_x[SLICE_W-1] ^ w_y[SLICE_W-1] ^ w_s[SLICE_W-1];
  assign ovf       = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_ovf <= 1'b0;
    else if ((r_state == ADD) && w_last)   r_ovf <= w_msb_cin ^ w_co;
  end
`endif

endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboarded bench for multiword_add_seq (WORDS=4): directed corner cases plus 1000 random back-to-back ops.
module tb_multiword_add_seq;
  localparam int WORDS = 4;
  localparam int N     = 16 * WORDS;

  typedef struct packed {
    logic         ovf;
    logic         cout;
    logic [N-1:0] sum;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
`ifdef MULTIWORD_ADD_SIGNED_OVF_EN
  logic         ovf;
`endif

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic prev_ov = 1'b0;
  exp_t mon_e;

  multiword_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef MULTIWORD_ADD_SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [N:0] act, input logic [N:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: unsigned (N+1)-bit sum for cout/sum, exact signed sum for overflow.
  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    logic [N:0]   u;
    logic [N+1:0] s;
    exp_t         e;
    u = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
    s = {{2{x[N-1]}}, x} + {{2{y[N-1]}}, y} + {{(N+1){1'b0}}, c};
    e.sum  = u[N-1:0];
    e.cout = u[N];
    e.ovf  = s[N] ^ s[N-1];
    return e;
  endfunction

  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input logic c,
                       input bit push, output int acc);
    int g;
    g        = 0;
    a        = x;
    b        = y;
    cin      = c;
    in_valid = 1'b1;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready still %b after %0d cycles, expected 1", in_ready, g);
      in_valid = 1'b0;
      acc      = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc      = cyc;
    in_valid = 1'b0;
    if (push) begin
      exp_q.push_back(model(x, y, c));
      acc_q.push_back(cyc);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  // Monitor: latency on each rising out_valid, result on each handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL latency: out_valid rose with no accepted op outstanding");
        end else begin
          chk("latency", (N+1)'(cyc - acc_q.pop_front()), (N+1)'(WORDS));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: sum=%h cout=%b with empty scoreboard", sum, cout);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result", {cout, sum}, {mon_e.cout, mon_e.sum});
`ifdef MULTIWORD_ADD_SIGNED_OVF_EN
          chk("ovf", {{N{1'b0}}, ovf}, {{N{1'b0}}, mon_e.ovf});
`endif
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc;
    int   last;
    int   g;
    exp_t e;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic c;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {{N{1'b0}}, in_ready}, (N+1)'(1));
    chk("rst_out_valid", {{N{1'b0}}, out_valid}, '0);
    chk("rst_sum_cout", {cout, sum}, '0);
`ifdef MULTIWORD_ADD_SIGNED_OVF_EN
    chk("rst_ovf", {{N{1'b0}}, ovf}, '0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b1, acc);
    drain();
    chk("slice_carry_held", {cout, sum}, {1'b0, 64'h0000_0000_0001_0000});

    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1, acc);
    drain();
    chk("full_ripple_held", {cout, sum}, {1'b1, 64'h0});
`ifdef MULTIWORD_ADD_SIGNED_OVF_EN
    chk("full_ripple_ovf", {{N{1'b0}}, ovf}, '0);
`endif

    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, acc);
    drain();
    chk("signed_wrap_held", {cout, sum}, {1'b0, 64'h8000_0000_0000_0000});
`ifdef MULTIWORD_ADD_SIGNED_OVF_EN
    chk("signed_wrap_ovf", {{N{1'b0}}, ovf}, (N+1)'(1));
`endif

    // Consumer stall: result must hold and fresh operands must be ignored.
    out_ready = 1'b0;
    x = {$urandom(), $urandom()};
    y = {$urandom(), $urandom()};
    c = 1'($urandom_range(0, 1));
    e = model(x, y, c);
    issue(x, y, c, 1'b1, acc);
    g = 0;
    while (!out_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("stall_out_valid", {{N{1'b0}}, out_valid}, (N+1)'(1));
      chk("stall_in_ready", {{N{1'b0}}, in_ready}, '0);
      chk("stall_hold", {cout, sum}, {e.cout, e.sum});
      in_valid = 1'b1;
      a        = {$urandom(), $urandom()};
      b        = {$urandom(), $urandom()};
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", {{N{1'b0}}, in_ready}, (N+1)'(1));
    chk("release_out_valid", {{N{1'b0}}, out_valid}, '0);
    repeat (6) @(posedge clk);
    #1;
    chk("no_ghost_op", {{N{1'b0}}, out_valid}, '0);
    chk("scoreboard_empty", (N+1)'(exp_q.size()), '0);

    // Reset in the second ADD cycle abandons the op.
    issue({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1, 1'b0, acc);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {{N{1'b0}}, in_ready}, (N+1)'(1));
    chk("midrst_out_valid", {{N{1'b0}}, out_valid}, '0);
    chk("midrst_sum_cout", {cout, sum}, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_hold_ov", {{N{1'b0}}, out_valid}, '0);
    end
    rst_n = 1'b1;
    issue(64'h1234, 64'hABCD, 1'b0, 1'b1, acc);
    drain();
    chk("post_rst_sum", {cout, sum}, {1'b0, 64'h0000_0000_0000_BE01});

    // Back-to-back random ops with an always-ready consumer.
    last = -1;
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom(), $urandom()};
      y = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) x = '1;
      if ($urandom_range(0, 7) == 0) y = {1'b0, {(N-1){1'b1}}};
      c = 1'($urandom_range(0, 1));
      issue(x, y, c, 1'b1, acc);
      if (last >= 0) chk("issue_interval", (N+1)'(acc - last), (N+1)'(WORDS + 2));
      last = acc;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 SHALL have parameter WORDS, default 4, meaning the number of 16-bit slices per operand (operand width N = 16*WORDS, WORDS >= 2).
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand transfer request.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  N  operand A.
REQ-007 SHALL have port b  input  N  operand B.
REQ-008 SHALL have port cin  input  1  carry-in to the least significant slice.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port sum  output  N  registered sum.
REQ-012 SHALL have port cout  output  1  carry-out of the most significant slice.

Function
REQ-013 SHALL implement FSM states IDLE, ADD and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE.
REQ-015 SHALL, in IDLE on in_valid&&in_ready, latch a, b and cin, clear slice index idx to 0, and go to ADD.
REQ-016 SHALL, in each ADD cycle, add slice idx of A, slice idx of B and the carry register through one 16-bit adder, write the 16-bit result into sum slice idx, load the carry register from the adder carry-out, and increment idx.
REQ-017 SHALL go from ADD to DONE on the cycle that processes idx==WORDS-1, loading cout from that slice's carry-out.
REQ-018 SHALL drive out_valid=1 only in DONE, holding sum and cout stable until out_ready=1, then return to IDLE.
REQ-019 SHALL raise out_valid exactly WORDS cycles after the accepting edge; minimum issue interval is WORDS+2 cycles.
REQ-020 SHALL ignore a, b, cin and in_valid outside IDLE, as operands are latched.
REQ-021 SHALL produce {cout,sum} == a+b+cin, modulo 2^(N+1).
REQ-022 SHALL propagate carry across all slices: a=all-ones, b=0, cin=1 gives sum=0, cout=1.
REQ-023 SHALL keep sum and cout at their last values after the handshake, until the next ADD overwrites them slice by slice.

Reset
REQ-024 SHALL, on rst_n=0 and regardless of clk, force state=IDLE, idx=0, carry=0, sum=0 and cout=0, giving in_ready=1 and out_valid=0.
REQ-025 SHALL abandon an operation in progress on reset mid-ADD or mid-DONE, with no output handshake occurring.
REQ-026 SHALL accept operands on the first rising edge after rst_n deasserts when in_valid=1.

Configuration
REQ-027 SHALL, with macro MULTIWORD_ADD_SIGNED_OVF_EN defined, add output port ovf (1 bit), registered with cout and valid with out_valid, equal to carry-into-MSB XOR carry-out-of-MSB (two's-complement overflow of the N-bit result), reset to 0.
REQ-028 SHALL, without the macro, have neither the ovf port nor its logic, with all other behaviour identical.

Structure
REQ-029 SHALL take SLICE_W=16 and the state enum typedef (IDLE/ADD/DONE) from package multiword_add_pkg.
REQ-030 SHALL instantiate exactly one combinational sub-module adder16_core (16-bit X, Y, cin in; S, cout out), reused for every slice.

Verification (WORDS=4)
REQ-031 SHALL cover: a=0x0000_0000_0000_FFFF, b=0x1, cin=0 -> sum=0x0000_0000_0001_0000, cout=0, out_valid 4 cycles after accept.
REQ-032 SHALL cover: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1; ovf=0 with macro.
REQ-033 SHALL cover: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0x8000_0000_0000_0000, cout=0; ovf=1 with macro.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles after out_valid -> sum/cout stable, in_ready=0, second in_valid ignored; on release, in_ready=1 next cycle.
REQ-035 SHALL cover: rst_n pulsed low during second ADD cycle -> out_valid never rises, sum=0, in_ready=1 immediately; next op a=0x1234, b=0xABCD -> sum=0xBE01.
REQ-036 SHALL cover: 1000 random back-to-back ops with out_ready=1 -> every result matches a+b+cin, issue interval exactly 6 cycles.
